vga_pixel_buffer: RTL and testbench

VGA_PIXEL_BUFFER -- requirements
Module: vga_pixel_buffer

---
 rtl/vga_pkg.sv | 10 +
 rtl/vga_pixel_buffer_if.sv | 11 +
 rtl/d_reg_sync.sv | 19 +
 rtl/vga_pixel_buffer.sv | 102 ++++++++++
 tb/tb_vga_pixel_buffer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared widths and colour defaults for the VGA pixel buffer.
package vga_pkg;
   localparam int RGB_W = 8;
   localparam int BUF_W = 16;

   localparam logic [RGB_W-1:0] FG_DEF  = 8'hFF;
   localparam logic [RGB_W-1:0] BG_DEF  = 8'h00;
   localparam logic [RGB_W-1:0] ERR_DEF = 8'hE0;
   localparam logic [RGB_W-1:0] BLANK   = 8'h00;
endpackage

// File: rtl/vga_pixel_buffer_if.sv
// Bus-side write port into the pixel buffer: one data word plus per-buffer write enables.
interface vga_pixel_buffer_if
   import vga_pkg::*;
   ;
   logic [BUF_W-1:0] bus_data;
   logic             buf0_we;
   logic             buf1_we;

   modport master (output bus_data, output buf0_we, output buf1_we);
   modport slave  (input  bus_data, input  buf0_we, input  buf1_we);
endinterface

// File: rtl/d_reg_sync.sv
// Generic D register with load enable and synchronous active-high reset to zero.
module d_reg_sync #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] q_q;

   always_ff @(posedge clk) begin
      if (reset)     q_q <= '0;
      else if (en_i) q_q <= d_i;
   end

   assign q_o = q_q;
endmodule

// File: rtl/vga_pixel_buffer.sv
// Double-buffered 1bpp pixel source: bus fills a buffer, display drains the selected one.
// Outputs and syncs share a single register stage so they stay aligned.
module vga_pixel_buffer
   import vga_pkg::*;
#(
   parameter logic [RGB_W-1:0] FG_COLOR  = FG_DEF,
   parameter logic [RGB_W-1:0] BG_COLOR  = BG_DEF,
   parameter logic [RGB_W-1:0] ERR_COLOR = ERR_DEF
) (
   input  logic              clk,
   input  logic              reset,
   vga_pixel_buffer_if.slave bus,
   input  logic              buf_sel,
   input  logic              buf_byte_sel,
   input  logic [10:0]       col,
   input  logic              vga_output_valid,
   input  logic              hsync_in,
   input  logic              vsync_in,
   output logic [RGB_W-1:0]  pixel_rgb,
   output logic              hsync,
   output logic              vsync,
   output logic              underrun,
   output logic [15:0]       underrun_count
);
   logic [1:0]            we;
   logic [1:0][BUF_W-1:0] buf_q;
   logic [1:0]            full_q, full_d;
   logic                  sel_prev_q;
   logic [15:0]           cnt_q, cnt_d;
   logic [BUF_W-1:0]      cur_buf;
   logic [7:0]            cur_byte;
   logic                  pix_bit;
   logic [RGB_W-1:0]      rgb_d;
   logic                  underrun_d;
   logic                  unused_col;

   assign we = {bus.buf1_we, bus.buf0_we};

   for (genvar n = 0; n < 2; n++) begin : g_buf
      d_reg_sync #(.W(BUF_W)) u_buf (
         .clk  (clk),
         .reset(reset),
         .en_i (we[n]),
         .d_i  (bus.bus_data),
         .q_o  (buf_q[n])
      );
   end

   // A buffer drains when display leaves it; a write on the same edge keeps it full.
   always_comb begin
      full_d = full_q;
      for (int n = 0; n < 2; n++) begin
         if (we[n])                                         full_d[n] = 1'b1;
         else if (sel_prev_q == n[0] && buf_sel != n[0])    full_d[n] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full_q     <= '0;
         sel_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         full_q     <= full_d;
         sel_prev_q <= buf_sel;
         cnt_q      <= cnt_d;
      end
   end

   assign cur_buf    = buf_q[buf_sel];
   assign cur_byte   = buf_byte_sel ? cur_buf[15:8] : cur_buf[7:0];
   assign pix_bit    = cur_byte[3'd7 - col[2:0]];
   assign unused_col = ^col[10:3];

   always_comb begin
      rgb_d      = BLANK;
      underrun_d = 1'b0;
      if (vga_output_valid) begin
         if (!full_q[buf_sel]) begin
            rgb_d      = ERR_COLOR;
            underrun_d = 1'b1;
         end else begin
            rgb_d = pix_bit ? FG_COLOR : BG_COLOR;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (underrun_d && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
   end

   d_reg_sync #(.W(RGB_W + 3)) u_pipe (
      .clk  (clk),
      .reset(reset),
      .en_i (1'b1),
      .d_i  ({rgb_d, hsync_in, vsync_in, underrun_d}),
      .q_o  ({pixel_rgb, hsync, vsync, underrun})
   );

   assign underrun_count = cnt_q;
endmodule

// File: tb/tb_vga_pixel_buffer.sv
// Directed bench for vga_pixel_buffer: fill/drain, bit order, underrun and count saturation.
module tb_vga_pixel_buffer;
   import vga_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        buf_sel, buf_byte_sel, vga_output_valid, hsync_in, vsync_in;
   logic [10:0] col;
   logic [7:0]  pixel_rgb;
   logic        hsync, vsync, underrun;
   logic [15:0] underrun_count;

   int checks = 0;
   int failures = 0;

   vga_pixel_buffer_if bif ();

   vga_pixel_buffer dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bif),
      .buf_sel         (buf_sel),
      .buf_byte_sel    (buf_byte_sel),
      .col             (col),
      .vga_output_valid(vga_output_valid),
      .hsync_in        (hsync_in),
      .vsync_in        (vsync_in),
      .pixel_rgb       (pixel_rgb),
      .hsync           (hsync),
      .vsync           (vsync),
      .underrun        (underrun),
      .underrun_count  (underrun_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_a5 [8];
   logic       hs_exp, vs_exp;

   initial begin
      exp_a5 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
      reset = 1'b1; buf_sel = 1'b0; buf_byte_sel = 1'b0; col = '0;
      vga_output_valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      bif.bus_data = 16'hABCD; bif.buf0_we = 1'b1; bif.buf1_we = 1'b0;

      // reset with a concurrent write: write must be discarded
      step();
      chk("rst_rgb", pixel_rgb, 8'h00);
      chk("rst_hsync", hsync, 1'b0);
      chk("rst_vsync", vsync, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_count", underrun_count, 16'd0);

      reset = 1'b0; bif.buf0_we = 1'b0; vga_output_valid = 1'b1;
      hsync_in = 1'b0; vsync_in = 1'b0;
      step();
      chk("first_err_rgb", pixel_rgb, 8'hE0);
      chk("first_underrun", underrun, 1'b1);
      chk("first_count", underrun_count, 16'd1);

      // fill buffer 0
      vga_output_valid = 1'b0; bif.buf0_we = 1'b1; bif.bus_data = 16'hA500;
      step();
      chk("blank_rgb", pixel_rgb, 8'h00);
      chk("blank_underrun", underrun, 1'b0);

      bif.buf0_we = 1'b0; vga_output_valid = 1'b1; buf_byte_sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         col = 11'(i);
         step();
         chk($sformatf("hi_col%0d", i), pixel_rgb, exp_a5[i]);
         chk($sformatf("hi_ur%0d", i), underrun, 1'b0);
      end
      chk("hi_count", underrun_count, 16'd1);

      buf_byte_sel = 1'b0;
      for (int i = 0; i < 8; i++) begin
         col = 11'(8 + i);
         step();
         chk($sformatf("lo_col%0d", i), pixel_rgb, 8'h00);
         chk($sformatf("lo_ur%0d", i), underrun, 1'b0);
      end

      // fill buffer 1, swap to it (drains 0), swap back -> underrun
      vga_output_valid = 1'b0; bif.buf1_we = 1'b1; bif.bus_data = 16'hFFFF;
      step();
      bif.buf1_we = 1'b0; buf_sel = 1'b1; vga_output_valid = 1'b1;
      buf_byte_sel = 1'b1; col = 11'd0;
      step();
      chk("buf1_rgb", pixel_rgb, 8'hFF);
      chk("buf1_ur", underrun, 1'b0);
      buf_sel = 1'b0;
      step();
      chk("drain0_rgb", pixel_rgb, 8'hE0);
      chk("drain0_ur", underrun, 1'b1);
      chk("drain0_count", underrun_count, 16'd2);

      // write on the same edge buffer 0 is left: set wins
      vga_output_valid = 1'b0; buf_sel = 1'b1;
      bif.buf0_we = 1'b1; bif.bus_data = 16'hA500;
      step();
      bif.buf0_we = 1'b0; buf_sel = 1'b0; vga_output_valid = 1'b1;
      col = 11'd0;
      step();
      chk("setwins_rgb0", pixel_rgb, 8'hFF);
      chk("setwins_ur", underrun, 1'b0);
      chk("setwins_count", underrun_count, 16'd2);

      // same-cycle write is not visible until the next cycle
      bif.buf0_we = 1'b1; bif.bus_data = 16'h0000;
      step();
      chk("nobypass_old", pixel_rgb, 8'hFF);
      bif.buf0_we = 1'b0;
      step();
      chk("nobypass_new", pixel_rgb, 8'h00);

      // 70000 underrun cycles on drained buffer 1; syncs follow by one cycle
      buf_sel = 1'b1;
      for (int i = 1; i <= 70000; i++) begin
         hs_exp = ((i % 7) < 3);
         vs_exp = ((i % 11) == 0);
         hsync_in = hs_exp; vsync_in = vs_exp;
         step();
         chk("sat_hsync", hsync, hs_exp);
         chk("sat_vsync", vsync, vs_exp);
         if (i == 65532) chk("sat_pre", underrun_count, 16'hFFFE);
         if (i == 65533) chk("sat_hit", underrun_count, 16'hFFFF);
      end
      chk("sat_end", underrun_count, 16'hFFFF);
      chk("sat_ur", underrun, 1'b1);
      chk("sat_rgb", pixel_rgb, 8'hE0);

      reset = 1'b1;
      step();
      chk("rst2_count", underrun_count, 16'd0);
      chk("rst2_rgb", pixel_rgb, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
